// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Animated multi-sprite address generation and 2-stage
//             transparency/priority compositing over the background colour.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_compositor #(
    parameter int                 NUM_SPRITES = 4,
    parameter int                 SPRITE_W    = 32,
    parameter int                 SPRITE_H    = 64,
    parameter int                 X_W         = 11,
    parameter int                 Y_W         = 10,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F,
    parameter int                 FRAMES      = 4,
    parameter int                 FRAME_DIV   = 8,
    localparam int                c_F_W       = $clog2(FRAMES),
    localparam int                c_LX_W      = $clog2(SPRITE_W),
    localparam int                c_LY_W      = $clog2(SPRITE_H),
    localparam int                c_AW        = 2 + c_F_W + c_LY_W + c_LX_W,
    localparam int                c_ID_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic [X_W-1:0]                 draw_x,
    input  logic [Y_W-1:0]                 draw_y,
    input  logic [COLOR_W-1:0]             bg_rgb,
    input  logic [NUM_SPRITES*X_W-1:0]     spr_x,
    input  logic [NUM_SPRITES*Y_W-1:0]     spr_y,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES-1:0]         spr_moving,
    input  logic [NUM_SPRITES*2-1:0]       spr_dir,
    output logic [NUM_SPRITES*c_AW-1:0]    rom_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0]             pix_rgb,
    output logic                           pix_hit,
    output logic [c_ID_W-1:0]              pix_id
);

    localparam int c_DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } anim_state_t;

    logic [NUM_SPRITES-1:0] w_hit0;
    logic [NUM_SPRITES-1:0] r_hit1;
    logic [COLOR_W-1:0]     r_bg1;
    logic [COLOR_W-1:0]     w_rgb;
    logic                   w_hit;
    logic [c_ID_W-1:0]      w_id;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic [X_W-1:0]     r_sx;
        logic [Y_W-1:0]     r_sy;
        logic               r_sen;
        logic [1:0]         r_sdir;
        anim_state_t        r_state;
        anim_state_t        w_state_nxt;
        logic [c_DIV_W-1:0] r_div;
        logic [c_DIV_W-1:0] w_div_nxt;
        logic [c_F_W-1:0]   r_frame;
        logic [c_F_W-1:0]   w_frame_nxt;
        logic [X_W:0]       w_x_end;
        logic [Y_W:0]       w_y_end;
        logic [c_LX_W-1:0]  w_lx;
        logic [c_LY_W-1:0]  w_ly;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sx    <= '0;
                r_sy    <= '0;
                r_sen   <= 1'b0;
                r_sdir  <= 2'd0;
                r_state <= S_IDLE;
                r_div   <= '0;
                r_frame <= '0;
            end else begin
                if (tick) begin
                    r_sx   <= spr_x[g*X_W +: X_W];
                    r_sy   <= spr_y[g*Y_W +: Y_W];
                    r_sen  <= spr_en[g];
                    r_sdir <= spr_dir[g*2 +: 2];
                end
                r_state <= w_state_nxt;
                r_div   <= w_div_nxt;
                r_frame <= w_frame_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_div_nxt   = r_div;
            w_frame_nxt = r_frame;
            if (tick) begin
                if (spr_moving[g]) begin
                    w_state_nxt = S_WALK;
                    if (r_div == c_DIV_W'(FRAME_DIV - 1)) begin
                        w_div_nxt   = '0;
                        w_frame_nxt = r_frame + c_F_W'(1);
                    end else begin
                        w_div_nxt   = r_div + c_DIV_W'(1);
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                    w_frame_nxt = '0;
                end
            end
        end

        // One extra bit keeps sprites near the coordinate limit from wrapping to 0.
        assign w_x_end   = {1'b0, r_sx} + (X_W+1)'(SPRITE_W);
        assign w_y_end   = {1'b0, r_sy} + (Y_W+1)'(SPRITE_H);
        assign w_hit0[g] = r_sen
                         && (draw_x >= r_sx) && ({1'b0, draw_x} < w_x_end)
                         && (draw_y >= r_sy) && ({1'b0, draw_y} < w_y_end);
        assign w_lx      = draw_x[c_LX_W-1:0] - r_sx[c_LX_W-1:0];
        assign w_ly      = draw_y[c_LY_W-1:0] - r_sy[c_LY_W-1:0];

        assign rom_addr[g*c_AW +: c_AW] = w_hit0[g] ? {r_sdir, r_frame, w_ly, w_lx} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit1 <= '0;
            r_bg1  <= '0;
        end else begin
            r_hit1 <= w_hit0;
            r_bg1  <= bg_rgb;
        end
    end

    // Scanning downward lets the lowest opaque index overwrite higher ones.
    always_comb begin
        w_rgb = r_bg1;
        w_hit = 1'b0;
        w_id  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_hit1[i] && (rom_data[i*COLOR_W +: COLOR_W] != TRANSPARENT)) begin
                w_rgb = rom_data[i*COLOR_W +: COLOR_W];
                w_hit = 1'b1;
                w_id  = c_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rgb <= '0;
            pix_hit <= 1'b0;
            pix_id  <= '0;
        end else begin
            pix_rgb <= w_rgb;
            pix_hit <= w_hit;
            pix_id  <= w_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// Testbench for sprite_compositor: directed vectors plus a per-cycle
// coordinate-level reference model of hit tests, animation and priority.
module tb_sprite_compositor;
    localparam int N  = 4;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int CW = 12;
    localparam int SW = 32;
    localparam int SH = 64;
    localparam int FR = 4;
    localparam int FD = 8;
    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic [XW-1:0]   draw_x;
    logic [YW-1:0]   draw_y;
    logic [CW-1:0]   bg_rgb;
    logic [N*XW-1:0] spr_x;
    logic [N*YW-1:0] spr_y;
    logic [N-1:0]    spr_en;
    logic [N-1:0]    spr_moving;
    logic [N*2-1:0]  spr_dir;
    logic [N*AW-1:0] rom_addr;
    logic [N*CW-1:0] rom_data = '0;
    logic [CW-1:0]   pix_rgb;
    logic            pix_hit;
    logic [1:0]      pix_id;

    logic [N-1:0]    f_en;
    logic [CW-1:0]   f_val [N];

    int n_cmp = 0;
    int n_bad = 0;

    sprite_compositor dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .draw_x(draw_x), .draw_y(draw_y), .bg_rgb(bg_rgb),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
        .spr_moving(spr_moving), .spr_dir(spr_dir),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_rgb(pix_rgb), .pix_hit(pix_hit), .pix_id(pix_id)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] rom_fn(int i, logic [AW-1:0] a);
        if (a[2:0] == 3'b011) return 12'hF0F;
        return CW'(int'(a) * 7 + i * 300 + 1);
    endfunction

    // Sprite ROMs: registered lookup, optionally overridden by a forced value.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            rom_data[i*CW +: CW] <= f_en[i] ? f_val[i] : rom_fn(i, rom_addr[i*AW +: AW]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int m_sx [N];
    int m_sy [N];
    int m_dir [N];
    int m_mt [N];
    bit m_en [N];
    int xi, yi, ea;
    bit eh;
    logic [CW-1:0] dv, c_rgb, q1_rgb = '0, q2_rgb = '0, e_rgb;
    bit c_hit, q1_hit = 1'b0, q2_hit = 1'b0, e_hit;
    int c_id, q1_id = 0, q2_id = 0, e_id;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_sx[i] = 0; m_sy[i] = 0; m_dir[i] = 0; m_mt[i] = 0; m_en[i] = 1'b0;
            end
        end
        xi = int'(draw_x);
        yi = int'(draw_y);
        c_rgb = bg_rgb; c_hit = 1'b0; c_id = 0;
        for (int i = 0; i < N; i++) begin
            eh = m_en[i] && xi >= m_sx[i] && xi < m_sx[i] + SW
                         && yi >= m_sy[i] && yi < m_sy[i] + SH;
            ea = eh ? m_dir[i] * (FR * SH * SW) + ((m_mt[i] / FD) % FR) * (SH * SW)
                      + (yi - m_sy[i]) * SW + (xi - m_sx[i]) : 0;
            chk($sformatf("rom_addr[%0d]", i), int'(rom_addr[i*AW +: AW]), ea);
            dv = f_en[i] ? f_val[i] : rom_fn(i, AW'(ea));
            if (!c_hit && eh && dv != 12'hF0F) begin
                c_rgb = dv; c_hit = 1'b1; c_id = i;
            end
        end
        if (!rst_n) begin
            e_rgb = '0; e_hit = 1'b0; e_id = 0;
        end else begin
            e_rgb = q2_rgb; e_hit = q2_hit; e_id = q2_id;
        end
        chk("pix_rgb", int'(pix_rgb), int'(e_rgb));
        chk("pix_hit", int'(pix_hit), int'(e_hit));
        chk("pix_id", int'(pix_id), e_id);
        if (!rst_n) begin
            q2_rgb = '0; q2_hit = 1'b0; q2_id = 0;
            q1_rgb = '0; q1_hit = 1'b0; q1_id = 0;
        end else begin
            q2_rgb = q1_rgb; q2_hit = q1_hit; q2_id = q1_id;
            q1_rgb = c_rgb;  q1_hit = c_hit;  q1_id = c_id;
        end
        if (rst_n && tick) begin
            for (int i = 0; i < N; i++) begin
                m_sx[i]  = int'(spr_x[i*XW +: XW]);
                m_sy[i]  = int'(spr_y[i*YW +: YW]);
                m_dir[i] = int'(spr_dir[i*2 +: 2]);
                m_en[i]  = spr_en[i];
                m_mt[i]  = spr_moving[i] ? m_mt[i] + 1 : 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drw(input int x, input int y);
        draw_x = XW'(x);
        draw_y = YW'(y);
    endtask

    task automatic set_spr(input int i, input int x, input int y, input bit en, input int d);
        spr_x[i*XW +: XW] = XW'(x);
        spr_y[i*YW +: YW] = YW'(y);
        spr_en[i]         = en;
        spr_dir[i*2 +: 2] = 2'(d);
    endtask

    initial begin
        draw_x = '0; draw_y = '0; bg_rgb = '0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_moving = '0; spr_dir = '0;
        f_en = '0;
        for (int i = 0; i < N; i++) f_val[i] = '0;
        repeat (3) nxt();
        rst_n = 1'b1;
        bg_rgb = 12'h123;
        nxt(); nxt();
        @(negedge clk);
        chk("bg_after_reset", int'(pix_rgb), 12'h123);

        // Single sprite at (800,400)
        nxt();
        set_spr(0, 800, 400, 1'b1, 0);
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        drw(805, 410); bg_rgb = 12'h555;
        f_en[0] = 1'b1; f_val[0] = 12'hABC;
        @(negedge clk);
        chk("addr_805_410", int'(rom_addr[0 +: AW]), 15'h145);
        nxt();
        drw(832, 410);
        @(negedge clk);
        chk("addr_832_miss", int'(rom_addr[0 +: AW]), 0);
        nxt();
        drw(0, 0);
        @(negedge clk);
        chk("lit_rgb_abc", int'(pix_rgb), 12'hABC);
        chk("lit_hit_abc", int'(pix_hit), 1);
        nxt();
        @(negedge clk);
        chk("lit_rgb_miss_bg", int'(pix_rgb), 12'h555);

        // Overlap priority with transparency
        nxt();
        set_spr(0, 100, 100, 1'b1, 0);
        set_spr(1, 100, 100, 1'b1, 0);
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        f_en[1:0] = 2'b11; f_val[0] = 12'hF0F; f_val[1] = 12'h0F0;
        drw(110, 120);
        nxt(); nxt();
        @(negedge clk);
        chk("lit_overlap_rgb", int'(pix_rgb), 12'h0F0);
        chk("lit_overlap_id", int'(pix_id), 1);
        nxt();
        f_val[0] = 12'h00F;
        nxt(); nxt();
        @(negedge clk);
        chk("lit_prio_rgb", int'(pix_rgb), 12'h00F);
        chk("lit_prio_id", int'(pix_id), 0);

        // Animation on sprite 2
        nxt();
        f_en = '0;
        set_spr(0, 0, 0, 1'b0, 0);
        set_spr(1, 0, 0, 1'b0, 0);
        set_spr(2, 300, 300, 1'b1, 3);
        spr_moving[2] = 1'b1;
        drw(300, 300);
        tick = 1'b1;
        repeat (8) nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("frame_after_8", int'(rom_addr[2*AW +: AW]), 15'h6800);
        nxt();
        tick = 1'b1;
        repeat (24) nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("frame_wrap_32", int'(rom_addr[2*AW +: AW]), 15'h6000);
        nxt();
        tick = 1'b1;
        repeat (8) nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("frame_after_40", int'(rom_addr[2*AW +: AW]), 15'h6800);
        nxt();
        spr_moving[2] = 1'b0;
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("frame_idle", int'(rom_addr[2*AW +: AW]), 15'h6000);
        nxt();
        spr_moving[2] = 1'b1;
        tick = 1'b1;
        repeat (7) nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("div_restart_7", int'(rom_addr[2*AW +: AW]), 15'h6000);
        nxt();
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("div_restart_8", int'(rom_addr[2*AW +: AW]), 15'h6800);

        // Shadowing: position changes take effect only on tick
        nxt();
        spr_moving[2] = 1'b0;
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        set_spr(2, 200, 300, 1'b1, 3);
        drw(205, 300);
        @(negedge clk);
        chk("shadow_old_miss", int'(rom_addr[2*AW +: AW]), 0);
        nxt();
        drw(305, 300);
        @(negedge clk);
        chk("shadow_old_hit", int'(rom_addr[2*AW +: AW]), 15'h6005);
        nxt();
        set_spr(2, 202, 300, 1'b1, 3);
        tick = 1'b1;
        drw(205, 300);
        nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("shadow_new_hit", int'(rom_addr[2*AW +: AW]), 15'h6003);

        // Sprite near the x limit must not alias to x=0
        nxt();
        set_spr(3, 2040, 0, 1'b1, 0);
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        for (int x = 0; x < 32; x++) begin
            drw(x, 5);
            nxt();
        end
        drw(5, 5);
        @(negedge clk);
        chk("edge_no_alias", int'(rom_addr[3*AW +: AW]), 0);
        nxt();
        drw(2045, 5);
        @(negedge clk);
        chk("edge_hit", int'(rom_addr[3*AW +: AW]), 15'h00A5);

        // Back-to-back random stream over overlapping sprites
        nxt();
        set_spr(0, 50, 60, 1'b1, 1);
        set_spr(1, 70, 80, 1'b1, 2);
        set_spr(2, 40, 100, 1'b1, 3);
        set_spr(3, 60, 50, 1'b1, 0);
        spr_moving = 4'b1010;
        tick = 1'b1;
        nxt();
        for (int k = 0; k < 64; k++) begin
            drw($urandom_range(30, 140), $urandom_range(40, 190));
            bg_rgb = CW'($urandom);
            tick = (k % 16 == 15);
            if (tick) spr_moving = N'($urandom);
            nxt();
        end
        tick = 1'b0;

        // Mid-stream asynchronous reset
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", int'(pix_rgb), 0);
        chk("rst_hit", int'(pix_hit), 0);
        chk("rst_id", int'(pix_id), 0);
        nxt();
        rst_n = 1'b1;
        bg_rgb = 12'h123;
        drw(70, 70);
        nxt(); nxt();
        @(negedge clk);
        chk("rst_release_bg", int'(pix_rgb), 12'h123);
        chk("rst_release_nohit", int'(pix_hit), 0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-sprite path in the game top.
- Composites NUM_SPRITES animated 32x64 sprites (players, enemies, bombs) over the tile/background colour.
- Generates per-sprite animated ROM addresses, then applies transparency keying and fixed index priority in a 2-stage pipeline.
- Sits between the vga_out pixel counters / drawcon background and the VGA colour output.

Parameters:
- NUM_SPRITES, 4, number of sprite channels; index 0 has highest priority.
- SPRITE_W, 32, sprite width in pixels; power of 2.
- SPRITE_H, 64, sprite height in pixels; power of 2.
- X_W, 11, width of x coordinates.
- Y_W, 10, width of y coordinates.
- COLOR_W, 12, RGB width (4:4:4).
- TRANSPARENT, 12'hF0F, colour key treated as "no pixel".
- FRAMES, 4, walk frames per direction; power of 2.
- FRAME_DIV, 8, ticks per animation frame; must be at least 1.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle pulse at frame start (x=0,y=0).
- draw_x  in  X_W  current pixel x (stage 0).
- draw_y  in  Y_W  current pixel y (stage 0).
- bg_rgb  in  COLOR_W  background colour aligned with draw_x/draw_y.
- spr_x  in  NUM_SPRITES*X_W  flat top-left x per sprite.
- spr_y  in  NUM_SPRITES*Y_W  flat top-left y per sprite.
- spr_en  in  NUM_SPRITES  sprite visible.
- spr_moving  in  NUM_SPRITES  sprite is walking; drives animation.
- spr_dir  in  NUM_SPRITES*2  direction per sprite: 0 down, 1 up, 2 left, 3 right.
- rom_addr  out  NUM_SPRITES*AW  flat ROM address per sprite; AW = 2+log2(FRAMES)+log2(SPRITE_H)+log2(SPRITE_W).
- rom_data  in  NUM_SPRITES*COLOR_W  ROM data; synchronous ROM, 1-cycle latency.
- pix_rgb  out  COLOR_W  composited colour.
- pix_hit  out  1  an opaque sprite pixel won.
- pix_id  out  log2(NUM_SPRITES) (min 1)  index of the winning sprite; 0 when pix_hit=0.

Behaviour:
- Shadow registers: on tick, spr_x, spr_y, spr_en and spr_dir are latched into per-sprite shadow registers. All hit tests and addresses use the shadows only, so there is no mid-frame tearing. Shadow reset value is 0; with en=0, nothing is drawn after reset until the first tick.
- Animation, per sprite: 2-state FSM IDLE/WALK plus div_cnt and frame_cnt.
  - On tick with spr_moving=1: state becomes WALK; div_cnt increments.
  - When div_cnt == FRAME_DIV-1 on tick: div_cnt wraps to 0 and frame_cnt increments modulo FRAMES (FRAMES-1 wraps to 0).
  - On tick with spr_moving=0: state becomes IDLE; div_cnt=0, frame_cnt=0.
  - Without tick, counters hold.
  - FRAME_DIV=1: frame advances on every moving tick.
- Stage 0 (combinational):
  - Per sprite: hit = en_s && draw_x>=x_s && draw_x<x_s+SPRITE_W && draw_y>=y_s && draw_y<y_s+SPRITE_H.
  - Sums are computed at X_W+1 / Y_W+1 bits, so sprites near the max coordinate neither wrap nor alias to x=0.
  - rom_addr = {dir_s, frame_cnt, local_y, local_x} when hit, else 0.
- Stage 1 (register, N+1): hit vector and bg_rgb are registered; rom_data is valid in this cycle.
- Stage 2 (register, N+2):
  - Lowest index i with hit1[i] && rom_data[i]!=TRANSPARENT wins: pix_rgb=rom_data[i], pix_hit=1, pix_id=i.
  - Otherwise pix_rgb=bg1, pix_hit=0, pix_id=0.
- Latency: exactly 2 clk from draw_x/draw_y/bg_rgb to pix_*. Fully pipelined, one pixel per clk, no stalls.
- Reset values: pix_rgb=0, pix_hit=0, pix_id=0, all pipeline registers 0, all FSMs IDLE, counters 0.
- Reset asserted mid-frame clears everything immediately. After release, outputs show bg for 2 cycles, then normal operation resumes; sprites reappear after the next tick.
- Simultaneous tick and spr_x change: the new value is latched (the tick sample wins).
- Overlap with the higher-index sprite opaque and the lower-index sprite transparent at that pixel: the higher-index sprite shows.

Test Plan:
- Reset with rst_n=0 mid-stream -> pix_rgb=0, pix_hit=0, pix_id=0 at once; after release and before any tick, bg_rgb=12'h123 gives pix_rgb=12'h123 two cycles later.
- Sprite0 at (800,400), en=1, dir=0, tick; draw (805,410) -> rom_addr0 = {2'd0,2'd0,6'd10,5'd5}; ROM returns 12'hABC; pix_rgb=12'hABC, pix_hit=1, pix_id=0 at N+2. Draw (832,410) -> miss, bg passes.
- Sprites 0 and 1 both at (100,100); ROM0 returns 12'hF0F, ROM1 returns 12'h0F0 -> pix_rgb=12'h0F0, pix_id=1. With ROM0=12'h00F -> pix_rgb=12'h00F, pix_id=0.
- spr_moving=1 for 8 ticks -> frame_cnt 0 to 1; after 32 ticks -> wraps to 0; spr_moving=0 on the next tick -> frame_cnt=0 and IDLE.
- spr_x changed to 200 without a tick -> hits still at the old x; after tick -> hits at 200. Sprite at x=2040 (X_W=11) -> no hit at draw_x=0..31.
- Back-to-back pixel stream over 64 cycles with a random ROM model -> output matches the reference model shifted by 2 cycles, with no bubbles.
